// File: rtl/collision_scorer.sv
// Collision and scoring engine: per-pipe hit/pass detection, score, lives,
// high score and a four-state game FSM behind a one-cycle detection stage.
module collision_scorer #(
    parameter int NUM_PIPES    = 4,
    parameter int COORD_W      = 10,
    parameter int SCORE_W      = 8,
    parameter int LIVES        = 3,
    parameter int MARGIN       = 2,
    parameter int FLOOR_Y      = 470,
    parameter int GRACE_CYCLES = 16
) (
    input  logic                         Clk,
    input  logic                         reset_n,
    input  logic                         Start,
    input  logic                         Ack,
    input  logic [COORD_W-1:0]           Bird_X_L,
    input  logic [COORD_W-1:0]           Bird_X_R,
    input  logic [COORD_W-1:0]           Bird_Y_T,
    input  logic [COORD_W-1:0]           Bird_Y_B,
    input  logic [NUM_PIPES-1:0]         Pipe_Valid,
    input  logic [NUM_PIPES*COORD_W-1:0] Pipe_X_L,
    input  logic [NUM_PIPES*COORD_W-1:0] Pipe_X_R,
    input  logic [NUM_PIPES*COORD_W-1:0] Gap_Top,
    input  logic [NUM_PIPES*COORD_W-1:0] Gap_Bot,
    output logic                         Q_Initial,
    output logic                         Q_Check,
    output logic                         Q_Hit,
    output logic                         Q_Over,
    output logic [SCORE_W-1:0]           Score,
    output logic [SCORE_W-1:0]           High_Score,
    output logic [2:0]                   Lives,
    output logic [2:0]                   Hit_Index,
    output logic                         Score_Pulse
);

    localparam int CW1   = COORD_W + 1;
    localparam int GW    = (GRACE_CYCLES > 0) ? $clog2(GRACE_CYCLES + 1) : 1;
    localparam int CNT_W = 4;

    localparam logic [CW1-1:0]     MG      = CW1'(MARGIN);
    localparam logic [CW1-1:0]     FLOOR_L = CW1'(FLOOR_Y);
    localparam logic [SCORE_W-1:0] SMAX    = '1;

    typedef enum logic [3:0] {
        S_INIT  = 4'b0001,
        S_CHECK = 4'b0010,
        S_HIT   = 4'b0100,
        S_OVER  = 4'b1000
    } state_t;

    state_t               state_q, state_d;
    logic [NUM_PIPES-1:0] hit_vec_q, hit_vec_d;
    logic [NUM_PIPES-1:0] pass_vec_q, pass_vec_d;
    logic [NUM_PIPES-1:0] passed_q, passed_d;
    logic                 floor_hit_q, floor_hit_d;
    logic [GW-1:0]        grace_q, grace_d;
    logic [SCORE_W-1:0]   score_q, score_d;
    logic [SCORE_W-1:0]   high_q, high_d;
    logic [2:0]           lives_q, lives_d;
    logic [2:0]           hit_index_q, hit_index_d;
    logic                 pulse_q, pulse_d;

    logic [CW1-1:0]       bxl, bxr, byt, byb;
    logic [NUM_PIPES-1:0] hit_raw, beyond;
    logic                 start_go;
    logic                 hit;
    logic [CNT_W-1:0]     pass_cnt;
    logic [2:0]           hit_idx;
    logic [SCORE_W:0]     sum;

    assign bxl = {1'b0, Bird_X_L};
    assign bxr = {1'b0, Bird_X_R};
    assign byt = {1'b0, Bird_Y_T};
    assign byb = {1'b0, Bird_Y_B};

    for (genvar g = 0; g < NUM_PIPES; g++) begin : g_slot
        logic [CW1-1:0] xl, xr, gt, gb;
        assign xl = {1'b0, Pipe_X_L[g*COORD_W +: COORD_W]};
        assign xr = {1'b0, Pipe_X_R[g*COORD_W +: COORD_W]};
        assign gt = {1'b0, Gap_Top[g*COORD_W +: COORD_W]};
        assign gb = {1'b0, Gap_Bot[g*COORD_W +: COORD_W]};
        assign hit_raw[g] = Pipe_Valid[g]
                          & (bxr > xl + MG)
                          & (bxl + MG < xr)
                          & ((byt + MG < gt) | (byb > gb + MG));
        assign beyond[g]  = Pipe_Valid[g] & (xr < bxl);
    end

    assign start_go = (state_q == S_INIT) & Start;

    // A game start forgets earlier passes, so a pipe already behind the bird counts once
    always_comb begin
        hit_vec_d   = hit_raw;
        floor_hit_d = (byb >= FLOOR_L);
        passed_d    = beyond;
        pass_vec_d  = beyond & ~(start_go ? '0 : passed_q);
    end

    always_comb begin
        pass_cnt = '0;
        for (int i = 0; i < NUM_PIPES; i++) begin
            pass_cnt = pass_cnt + CNT_W'(pass_vec_q[i]);
        end
    end

    always_comb begin
        hit_idx = 3'd7;
        for (int i = NUM_PIPES - 1; i >= 0; i--) begin
            if (hit_vec_q[i]) hit_idx = 3'(i);
        end
    end

    assign hit = ((|hit_vec_q) | floor_hit_q) & (grace_q == '0);
    assign sum = {1'b0, score_q} + (SCORE_W+1)'(pass_cnt);

    always_comb begin
        state_d     = state_q;
        score_d     = score_q;
        high_d      = high_q;
        lives_d     = lives_q;
        hit_index_d = hit_index_q;
        grace_d     = grace_q;
        pulse_d     = 1'b0;
        case (state_q)
            S_INIT: begin
                if (Start) begin
                    state_d = S_CHECK;
                    score_d = '0;
                    lives_d = 3'(LIVES);
                    grace_d = '0;
                end
            end
            S_CHECK: begin
                if (grace_q != '0) grace_d = grace_q - GW'(1);
                if (hit) begin
                    lives_d     = lives_q - 3'd1;
                    hit_index_d = hit_idx;
                    if (lives_q <= 3'd1) begin
                        state_d = S_OVER;
                        high_d  = (score_q > high_q) ? score_q : high_q;
                    end else begin
                        state_d = S_HIT;
                    end
                end else begin
                    score_d = sum[SCORE_W] ? SMAX : sum[SCORE_W-1:0];
                    pulse_d = (pass_cnt != '0);
                end
            end
            S_HIT: begin
                if (Ack) begin
                    state_d = S_CHECK;
                    grace_d = GW'(GRACE_CYCLES);
                end
            end
            S_OVER: begin
                if (Ack) state_d = S_INIT;
            end
            default: state_d = S_INIT;
        endcase
    end

    always_ff @(posedge Clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= S_INIT;
            hit_vec_q   <= '0;
            pass_vec_q  <= '0;
            passed_q    <= '0;
            floor_hit_q <= 1'b0;
            grace_q     <= '0;
            score_q     <= '0;
            high_q      <= '0;
            lives_q     <= 3'(LIVES);
            hit_index_q <= '0;
            pulse_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            hit_vec_q   <= hit_vec_d;
            pass_vec_q  <= pass_vec_d;
            passed_q    <= passed_d;
            floor_hit_q <= floor_hit_d;
            grace_q     <= grace_d;
            score_q     <= score_d;
            high_q      <= high_d;
            lives_q     <= lives_d;
            hit_index_q <= hit_index_d;
            pulse_q     <= pulse_d;
        end
    end

    assign Q_Initial   = state_q[0];
    assign Q_Check     = state_q[1];
    assign Q_Hit       = state_q[2];
    assign Q_Over      = state_q[3];
    assign Score       = score_q;
    assign High_Score  = high_q;
    assign Lives       = lives_q;
    assign Hit_Index   = hit_index_q;
    assign Score_Pulse = pulse_q;

endmodule

// File: tb/tb_collision_scorer.sv
// Bench for collision_scorer: geometry vector table through a scoreboard,
// plus sequences for scoring, grace, game over, reset and saturation.
module tb_collision_scorer;

    logic        Clk = 1'b0;
    logic        reset_n;
    logic        Start, Ack;
    logic [9:0]  Bird_X_L, Bird_X_R, Bird_Y_T, Bird_Y_B;
    logic [3:0]  Pipe_Valid;
    logic [39:0] Pipe_X_L, Pipe_X_R, Gap_Top, Gap_Bot;
    logic        Q_Initial, Q_Check, Q_Hit, Q_Over;
    logic [7:0]  Score, High_Score;
    logic [2:0]  Lives, Hit_Index;
    logic        Score_Pulse;

    int checks = 0;
    int errors = 0;

    collision_scorer dut (
        .Clk(Clk), .reset_n(reset_n), .Start(Start), .Ack(Ack),
        .Bird_X_L(Bird_X_L), .Bird_X_R(Bird_X_R),
        .Bird_Y_T(Bird_Y_T), .Bird_Y_B(Bird_Y_B),
        .Pipe_Valid(Pipe_Valid), .Pipe_X_L(Pipe_X_L), .Pipe_X_R(Pipe_X_R),
        .Gap_Top(Gap_Top), .Gap_Bot(Gap_Bot),
        .Q_Initial(Q_Initial), .Q_Check(Q_Check), .Q_Hit(Q_Hit),
        .Q_Over(Q_Over), .Score(Score), .High_Score(High_Score),
        .Lives(Lives), .Hit_Index(Hit_Index), .Score_Pulse(Score_Pulse)
    );

    always #5 Clk = ~Clk;

    typedef struct {
        int slot; bit valid; int byt; int byb;
        int xl; int xr; int gt; int gb;
        bit hit; int idx; int inc;
    } vec_t;

    typedef struct {
        bit hit; int lives; int idx; int score;
    } exp_t;

    vec_t tbl[14];
    exp_t sb[$];

    task automatic chk(input string nm, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    task automatic step();
        @(posedge Clk);
        @(negedge Clk);
    endtask

    task automatic set_slot(input int s, input bit v, input int xl,
                            input int xr, input int gt, input int gb);
        Pipe_Valid[s]       = v;
        Pipe_X_L[s*10 +: 10] = 10'(xl);
        Pipe_X_R[s*10 +: 10] = 10'(xr);
        Gap_Top[s*10 +: 10]  = 10'(gt);
        Gap_Bot[s*10 +: 10]  = 10'(gb);
    endtask

    task automatic do_reset();
        reset_n    = 1'b0;
        Start      = 1'b0;
        Ack        = 1'b0;
        Bird_X_L   = 10'd100;
        Bird_X_R   = 10'd120;
        Bird_Y_T   = 10'd200;
        Bird_Y_B   = 10'd220;
        Pipe_Valid = '0;
        Pipe_X_L   = '0;
        Pipe_X_R   = '0;
        Gap_Top    = '0;
        Gap_Bot    = '0;
        @(negedge Clk);
        @(negedge Clk);
        reset_n = 1'b1;
    endtask

    task automatic start_game();
        Start = 1'b1;
        step();
        Start = 1'b0;
    endtask

    initial begin
        exp_t e;
        int   n;

        // bird box is x 100..120, y 200..220 unless the vector moves it
        tbl[0]  = '{0, 1, 200, 220, 300, 350, 150, 300, 0, 0, 0};
        tbl[1]  = '{0, 1, 200, 220,  50,  99, 150, 300, 0, 0, 1};
        tbl[2]  = '{1, 1, 200, 220, 110, 160, 202, 300, 0, 0, 0};
        tbl[3]  = '{1, 1, 200, 220, 110, 160, 203, 300, 1, 1, 0};
        tbl[4]  = '{2, 1, 200, 220, 110, 160, 150, 218, 0, 0, 0};
        tbl[5]  = '{2, 1, 200, 220, 110, 160, 150, 217, 1, 2, 0};
        tbl[6]  = '{3, 1, 200, 220, 118, 160, 250, 300, 0, 0, 0};
        tbl[7]  = '{3, 1, 200, 220, 117, 160, 250, 300, 1, 3, 0};
        tbl[8]  = '{0, 1, 200, 220,  60, 102, 250, 300, 0, 0, 0};
        tbl[9]  = '{0, 1, 200, 220,  60, 103, 250, 300, 1, 0, 0};
        tbl[10] = '{0, 0, 200, 220, 117, 160, 250, 300, 0, 0, 0};
        tbl[11] = '{0, 0, 450, 470, 300, 350, 150, 300, 1, 7, 0};
        tbl[12] = '{0, 0, 449, 469, 300, 350, 150, 300, 0, 0, 0};
        tbl[13] = '{0, 1, 200, 220,  50, 100, 150, 300, 0, 0, 0};

        do_reset();
        chk("rst_q_initial", int'(Q_Initial), 1);
        chk("rst_q_others", int'({Q_Check, Q_Hit, Q_Over}), 0);
        chk("rst_score", int'(Score), 0);
        chk("rst_high", int'(High_Score), 0);
        chk("rst_lives", int'(Lives), 3);
        chk("rst_hit_index", int'(Hit_Index), 0);
        chk("rst_pulse", int'(Score_Pulse), 0);

        for (int i = 0; i < 14; i++) begin
            do_reset();
            Bird_Y_T = 10'(tbl[i].byt);
            Bird_Y_B = 10'(tbl[i].byb);
            set_slot(tbl[i].slot, tbl[i].valid, tbl[i].xl, tbl[i].xr,
                     tbl[i].gt, tbl[i].gb);
            e.hit   = tbl[i].hit;
            e.lives = tbl[i].hit ? 2 : 3;
            e.idx   = tbl[i].idx;
            e.score = tbl[i].inc;
            sb.push_back(e);
            start_game();
            step();
            e = sb.pop_front();
            chk($sformatf("v%0d_hit", i), int'(Q_Hit), int'(e.hit));
            chk($sformatf("v%0d_check", i), int'(Q_Check), int'(!e.hit));
            chk($sformatf("v%0d_lives", i), int'(Lives), e.lives);
            chk($sformatf("v%0d_idx", i), int'(Hit_Index), e.idx);
            chk($sformatf("v%0d_score", i), int'(Score), e.score);
        end

        // single pass: one pulse, no re-score while the slot is held
        do_reset();
        set_slot(0, 1, 50, 99, 150, 300);
        start_game();
        step();
        chk("p1_score", int'(Score), 1);
        chk("p1_pulse", int'(Score_Pulse), 1);
        step();
        chk("p1_pulse_off", int'(Score_Pulse), 0);
        repeat (5) step();
        chk("p1_hold", int'(Score), 1);

        // two slots pass together
        do_reset();
        start_game();
        step();
        set_slot(1, 1, 50, 99, 150, 300);
        set_slot(3, 1, 40, 90, 150, 300);
        step();
        step();
        chk("p2_score", int'(Score), 2);
        chk("p2_pulse", int'(Score_Pulse), 1);
        step();
        chk("p2_pulse_off", int'(Score_Pulse), 0);
        chk("p2_score_hold", int'(Score), 2);

        // floor and pipes together: lowest pipe slot wins
        do_reset();
        Bird_Y_T = 10'd450;
        Bird_Y_B = 10'd470;
        set_slot(2, 1, 110, 160, 150, 300);
        set_slot(3, 1, 110, 160, 150, 300);
        start_game();
        step();
        chk("fp_hit", int'(Q_Hit), 1);
        chk("fp_idx", int'(Hit_Index), 2);

        // hit and pass on the same cycle
        do_reset();
        start_game();
        step();
        set_slot(1, 1, 50, 99, 150, 300);
        set_slot(0, 1, 110, 160, 203, 300);
        step();
        step();
        chk("hp_hit", int'(Q_Hit), 1);
        chk("hp_score", int'(Score), 0);
        chk("hp_pulse", int'(Score_Pulse), 0);

        // grace window, three lives to game over
        do_reset();
        set_slot(1, 1, 50, 99, 150, 300);
        start_game();
        step();
        chk("g_score", int'(Score), 1);
        set_slot(0, 1, 110, 160, 203, 300);
        step();
        step();
        chk("g_hit1", int'(Q_Hit), 1);
        chk("g_lives1", int'(Lives), 2);
        chk("g_idx1", int'(Hit_Index), 0);
        for (int h = 0; h < 2; h++) begin
            Ack = 1'b1;
            step();
            Ack = 1'b0;
            chk($sformatf("g_ack%0d", h), int'(Q_Check), 1);
            n = 0;
            repeat (16) begin
                step();
                if (Q_Check) n++;
            end
            chk($sformatf("g_grace%0d", h), n, 16);
            step();
            chk($sformatf("g_rehit%0d", h), int'(Lives), 1 - h);
        end
        chk("g_over", int'(Q_Over), 1);
        chk("g_high", int'(High_Score), 1);
        Ack = 1'b1;
        step();
        Ack = 1'b0;
        chk("g_init", int'(Q_Initial), 1);
        chk("g_score_hold", int'(Score), 1);
        chk("g_high_hold", int'(High_Score), 1);

        // asynchronous reset in the middle of a game
        do_reset();
        set_slot(1, 1, 50, 99, 150, 300);
        start_game();
        step();
        chk("ar_pre_score", int'(Score), 1);
        #2;
        reset_n = 1'b0;
        #1;
        chk("ar_init", int'(Q_Initial), 1);
        chk("ar_check", int'(Q_Check), 0);
        chk("ar_score", int'(Score), 0);
        chk("ar_lives", int'(Lives), 3);
        @(negedge Clk);
        reset_n = 1'b1;

        // saturation: four passes per two cycles
        do_reset();
        start_game();
        step();
        for (int k = 0; k < 70; k++) begin
            for (int s = 0; s < 4; s++) set_slot(s, 1, 50, 99, 150, 300);
            step();
            Pipe_Valid = '0;
            step();
            if (k == 9) chk("sat_mid", int'(Score), 40);
        end
        step();
        chk("sat_score", int'(Score), 255);
        chk("sat_state", int'(Q_Check), 1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
